// File: rtl/mem_bist_pkg.sv
// Shared types, state encodings and LFSR step helper for the memory BIST master.
package mem_bist_pkg;

  typedef enum logic [1:0] {
    MODE_NONE  = 2'b00,
    MODE_FILL  = 2'b01,
    MODE_CHECK = 2'b10,
    MODE_BOTH  = 2'b11
  } mode_e;

  typedef logic [2:0] state_e;

  localparam state_e IDLE   = 3'd0;
  localparam state_e WRITE  = 3'd1;
  localparam state_e WDRAIN = 3'd2;
  localparam state_e READ   = 3'd3;
  localparam state_e RDRAIN = 3'd4;
  localparam state_e FIN    = 3'd5;

  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  // Right-shifting Galois step: feedback taps applied when bit 0 shifts out.
  function automatic logic [31:0] pattern_next(input logic [31:0] cur);
    logic [31:0] nxt;
    nxt = {1'b0, cur[31:1]};
    if (cur[0]) begin
      nxt = nxt ^ LFSR_POLY;
    end else begin
      nxt = nxt;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/mem_bist_pattern_gen.sv
// Per-word test pattern source. MEM_BIST_LFSR_EN selects a Galois LFSR sequence;
// otherwise the pattern is the word's byte address XOR the seed.
module mem_bist_pattern_gen
  import mem_bist_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic        step_i,
  input  logic [31:0] seed_i,
  input  logic [31:0] addr_i,
  output logic [31:0] data_o
);

`ifdef MEM_BIST_LFSR_EN
  logic [31:0] lfsr_r;
  logic        unused_s;

  assign unused_s = ^addr_i;

  // LFSR state: reseeded at phase start (an all-zero seed would lock up), stepped per word.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_r <= 32'h0000_0000;
    end else if (load_i) begin
      lfsr_r <= (seed_i == 32'h0000_0000) ? 32'h0000_0001 : seed_i;
    end else if (step_i) begin
      lfsr_r <= pattern_next(lfsr_r);
    end
  end

  assign data_o = lfsr_r;
`else
  logic unused_s;

  assign unused_s = ^{clk_i, rst_ni, load_i, step_i};
  assign data_o   = addr_i ^ seed_i;
`endif

endmodule

// File: rtl/mem_bist_master.sv
// Memory BIST bus initiator: fills and/or checks a word range over a req/gnt/rvalid port.
// Build with MEM_BIST_LFSR_EN defined for LFSR patterns instead of address^seed.
module mem_bist_master
  import mem_bist_pkg::*;
#(
  parameter logic [31:0] BaseAddr = 32'h0000_0000,
  parameter int unsigned NumWords = 128,
  parameter int unsigned MaxOutst = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [1:0]  mode_i,
  input  logic [31:0] seed_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        pass_o,
  output logic [15:0] err_cnt_o,
  output logic [31:0] first_err_addr_o,
  output logic        req_o,
  input  logic        gnt_i,
  output logic        we_o,
  output logic [3:0]  be_o,
  output logic [31:0] addr_o,
  output logic [31:0] wdata_o,
  input  logic        rvalid_i,
  input  logic [31:0] rdata_i
);

  localparam int unsigned IdxW = (NumWords > 1) ? $clog2(NumWords) : 1;
  localparam int unsigned OutW = $clog2(MaxOutst + 1);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumWords - 1);
  localparam logic [OutW-1:0] MaxOut  = OutW'(MaxOutst);
  localparam logic [OutW-1:0] OutZero = {OutW{1'b0}};

  state_e          state_r, state_s;
  mode_e           mode_r, mode_in_s;
  logic [31:0]     seed_r, seed_s;
  logic [IdxW-1:0] idx_r, rsp_idx_r;
  logic [OutW-1:0] outst_r;
  logic [15:0]     err_cnt_r;
  logic [31:0]     first_err_r;
  logic            done_r, pass_r;
  logic            start_acc_s, issue_st_s, gnt_s, rsp_s, rd_rsp_s, mismatch_s;
  logic            phase_load_s, chk_load_s;
  logic [31:0]     issue_addr_s, check_addr_s, issue_data_s, check_data_s;

  assign mode_in_s    = mode_e'(mode_i);
  assign start_acc_s  = start_i && (state_r == IDLE);
  assign issue_st_s   = (state_r == WRITE) || (state_r == READ);
  // A slot frees up in the same cycle when a response retires at the limit.
  assign req_o        = issue_st_s && ((outst_r < MaxOut) || ((outst_r == MaxOut) && rvalid_i));
  assign gnt_s        = req_o && gnt_i;
  assign rsp_s        = rvalid_i && (outst_r != OutZero);
  assign rd_rsp_s     = rsp_s && ((state_r == READ) || (state_r == RDRAIN));
  assign mismatch_s   = rd_rsp_s && (rdata_i != check_data_s);
  assign seed_s       = (state_r == IDLE) ? seed_i : seed_r;
  assign issue_addr_s = BaseAddr + (32'(idx_r) << 2'd2);
  assign check_addr_s = BaseAddr + (32'(rsp_idx_r) << 2'd2);
  assign phase_load_s = ((state_r == IDLE) && (state_s != IDLE)) ||
                        ((state_r == WDRAIN) && (state_s == READ));
  assign chk_load_s   = (state_s == READ) && (state_r != READ);

  // Next-state selection for the sweep sequencer.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_acc_s && (mode_in_s != MODE_NONE)) begin
          state_s = (mode_in_s == MODE_CHECK) ? READ : WRITE;
        end else begin
          state_s = IDLE;
        end
      end
      WRITE: begin
        if (gnt_s && (idx_r == LastIdx)) state_s = WDRAIN;
        else                             state_s = WRITE;
      end
      WDRAIN: begin
        if (outst_r == OutZero) state_s = (mode_r == MODE_BOTH) ? READ : FIN;
        else                    state_s = WDRAIN;
      end
      READ: begin
        if (gnt_s && (idx_r == LastIdx)) state_s = RDRAIN;
        else                             state_s = READ;
      end
      RDRAIN: begin
        if (outst_r == OutZero) state_s = FIN;
        else                    state_s = RDRAIN;
      end
      FIN:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Sequencer state, sampled command, word indices and outstanding-response count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r   <= IDLE;
      mode_r    <= MODE_NONE;
      seed_r    <= 32'h0000_0000;
      idx_r     <= {IdxW{1'b0}};
      rsp_idx_r <= {IdxW{1'b0}};
      outst_r   <= OutZero;
    end else begin
      state_r <= state_s;
      if (start_acc_s) begin
        mode_r <= mode_in_s;
        seed_r <= seed_i;
      end
      if (phase_load_s)  idx_r <= {IdxW{1'b0}};
      else if (gnt_s)    idx_r <= idx_r + IdxW'(1);
      if (chk_load_s)    rsp_idx_r <= {IdxW{1'b0}};
      else if (rd_rsp_s) rsp_idx_r <= rsp_idx_r + IdxW'(1);
      if (gnt_s && !rsp_s)      outst_r <= outst_r + OutW'(1);
      else if (!gnt_s && rsp_s) outst_r <= outst_r - OutW'(1);
    end
  end

  // Result reporting: error tally, first failing address, done pulse and verdict.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_cnt_r   <= 16'h0000;
      first_err_r <= 32'h0000_0000;
      done_r      <= 1'b0;
      pass_r      <= 1'b0;
    end else if (start_acc_s) begin
      err_cnt_r   <= 16'h0000;
      first_err_r <= 32'h0000_0000;
      done_r      <= (mode_in_s == MODE_NONE);
      pass_r      <= (mode_in_s == MODE_NONE);
    end else begin
      done_r <= (state_r == FIN);
      if (state_r == FIN) pass_r <= (err_cnt_r == 16'h0000);
      if (mismatch_s) begin
        if (err_cnt_r != 16'hFFFF) err_cnt_r   <= err_cnt_r + 16'h0001;
        if (err_cnt_r == 16'h0000) first_err_r <= check_addr_s;
      end
    end
  end

  mem_bist_pattern_gen u_issue_gen (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .load_i (phase_load_s),
    .step_i (gnt_s),
    .seed_i (seed_s),
    .addr_i (issue_addr_s),
    .data_o (issue_data_s)
  );

  mem_bist_pattern_gen u_check_gen (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .load_i (chk_load_s),
    .step_i (rd_rsp_s),
    .seed_i (seed_s),
    .addr_i (check_addr_s),
    .data_o (check_data_s)
  );

  assign busy_o           = (state_r != IDLE);
  assign done_o           = done_r;
  assign pass_o           = pass_r;
  assign err_cnt_o        = err_cnt_r;
  assign first_err_addr_o = first_err_r;
  assign we_o             = (state_r == WRITE);
  assign be_o             = 4'hF;
  assign addr_o           = issue_st_s ? issue_addr_s : 32'h0000_0000;
  assign wdata_o          = (state_r == WRITE) ? issue_data_s : 32'h0000_0000;

endmodule
